simt_dmac: RTL
==============

SIMT_DMAC -- requirements
Module: simt_dmac

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: DRAM handshake timeout in cycles; used only with SIMT_DMAC_TIMEOUT_EN.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- dmaCmd  in  2  00 none, 01 d2s (DRAM->SRAM), 10 s2d (SRAM->DRAM), 11 ignored
- dmaSrcAddress  in  32  source byte address
- dmaDstAddress  in  32  destination byte address
- dmaWidth  in  10  transfer length in 32-bit words
- sramReadData  in  32  SRAM read data, combinational from sramAddress
- dramReadData  in  32  DRAM read data, valid while dramValid=1
- dramValid  in  1  DRAM completion of the current read/write request
- sramAddress  out  14  SRAM word index
- sramWriteData  out  32  SRAM write data
- sramWriteEnable  out  1  SRAM write strobe
- dramAddress  out  32  DRAM byte address
- dramWriteData  out  32  DRAM write data
- dramWriteEnable  out  1  DRAM write request
- dramReadEnable  out  1  DRAM read request
- stall  out  1  CPU hold; high whenever not IDLE
- dmaError  out  1  sticky timeout flag; present only with SIMT_DMAC_TIMEOUT_EN

Function
REQ-003 SHALL use states IDLE, D2S_RD, D2S_WR, S2D_RD, S2D_WR.
REQ-004 In IDLE, dmaCmd=01 or 10 with dmaWidth!=0 SHALL latch src, dst, width and a word counter at the clock edge; the next state SHALL be D2S_RD or S2D_RD respectively.
REQ-005 dmaCmd=00, 11, or dmaWidth=0 SHALL be ignored; the block SHALL remain IDLE with no stall.
REQ-006 stall SHALL be a registered decode of state!=IDLE, so it asserts the cycle after the command and the CPU PC advances past the issuing instruction.
REQ-007 dmaCmd SHALL be ignored in every non-IDLE state.
REQ-008 D2S_RD: dramReadEnable=1 and dramAddress=current src; on dramValid=1, capture dramReadData and go to D2S_WR.
REQ-009 D2S_WR: exactly one cycle with sramWriteEnable=1, sramAddress=dst[15:2], sramWriteData=captured word.
REQ-010 S2D_RD: exactly one cycle with sramAddress=src[15:2]; capture sramReadData at the edge and go to S2D_WR.
REQ-011 S2D_WR: dramWriteEnable=1, dramAddress=current dst, dramWriteData=captured word, all held stable until dramValid=1.
REQ-012 After each word completes, src and dst SHALL each increase by 4 (32-bit wrap) and the counter SHALL decrement.
REQ-013 When the counter reaches 0, the next state SHALL be IDLE; otherwise it SHALL return to D2S_RD or S2D_RD.
REQ-014 Minimum per-word time SHALL be 2 cycles, when dramValid returns in the request's first cycle.
REQ-015 dramReadEnable and dramWriteEnable SHALL never be high together.
REQ-016 sramWriteEnable SHALL be 0 outside D2S_WR.
REQ-017 Idle outputs SHALL be 0.

Reset
REQ-018 Reset asserted SHALL immediately force IDLE and set all outputs, counters and latches to 0, including mid-transfer; the partial transfer SHALL be discarded.

Configuration
REQ-019 With SIMT_DMAC_TIMEOUT_EN defined:
- a counter SHALL count cycles spent in D2S_RD or S2D_WR without dramValid;
- on reaching TIMEOUT_CYCLES, the block SHALL abort to IDLE and set dmaError=1;
- dmaError SHALL be cleared only by reset.
REQ-020 Without SIMT_DMAC_TIMEOUT_EN, the block SHALL wait for dramValid indefinitely and SHALL have no dmaError port.

Verification
REQ-021 d2s: src=0x100, dst=0x40, width=3, dramValid immediate -> SRAM words 16,17,18 written with DRAM[0x100,0x104,0x108]; stall high exactly 6 cycles.
REQ-022 s2d: src=0x0, dst=0x2000, width=2, dramValid delayed 3 cycles -> dramWriteEnable held with constant address/data until valid; DRAM 0x2000/0x2004 correct; stall drops the cycle after the last valid.
REQ-023 dmaCmd=11, or dmaCmd=01 with width=0 -> stall stays 0; no SRAM or DRAM strobes.
REQ-024 Reset pulse during word 2 of a width=5 d2s -> all outputs 0 immediately; a new command after reset completes correctly.
REQ-025 dmaCmd=10 asserted while busy -> ignored; the in-flight transfer completes unchanged.
REQ-026 SIMT_DMAC_TIMEOUT_EN with TIMEOUT_CYCLES=8 and dramValid held 0 -> abort to IDLE after 8 cycles; dmaError=1 until reset.

Source files
------------

// File: rtl/simt_dmac.sv
// simt_dmac: single-channel word DMA between DRAM (byte addressed, handshaked)
// and SRAM (word indexed, single cycle). The CPU is held via stall while busy.
// Optional build macro SIMT_DMAC_TIMEOUT_EN adds a DRAM handshake timeout and
// the sticky dmaError output.
module simt_dmac #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  dmaCmd,
    input  logic [31:0] dmaSrcAddress,
    input  logic [31:0] dmaDstAddress,
    input  logic [9:0]  dmaWidth,
    input  logic [31:0] sramReadData,
    input  logic [31:0] dramReadData,
    input  logic        dramValid,
    output logic [13:0] sramAddress,
    output logic [31:0] sramWriteData,
    output logic        sramWriteEnable,
    output logic [31:0] dramAddress,
    output logic [31:0] dramWriteData,
    output logic        dramWriteEnable,
    output logic        dramReadEnable,
    output logic        stall
`ifdef SIMT_DMAC_TIMEOUT_EN
    ,
    output logic        dmaError
`endif
);

    typedef enum logic [2:0] {IDLE, D2S_RD, D2S_WR, S2D_RD, S2D_WR} state_t;

    state_t      state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] data;
    logic [9:0]  count;

    logic        cmd_d2s;
    logic        cmd_s2d;
    logic        last_word;
    logic        timed_out;
    logic [31:0] src_next;
    logic [31:0] dst_next;

    assign cmd_d2s   = (dmaCmd == 2'b01) && (dmaWidth != 10'd0);
    assign cmd_s2d   = (dmaCmd == 2'b10) && (dmaWidth != 10'd0);
    assign last_word = (count == 10'd1);
    assign src_next  = src + 32'd4;
    assign dst_next  = dst + 32'd4;

`ifdef SIMT_DMAC_TIMEOUT_EN
    // Cycles already spent waiting for dramValid in the current request.
    logic [31:0] to_count;
    assign timed_out = !dramValid && ((to_count + 32'd1) >= TIMEOUT_CYCLES);
`else
    assign timed_out = 1'b0;
`endif

    // State, transfer latches and registered outputs; outputs are loaded with
    // the values belonging to the state being entered, and default to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            src             <= 32'd0;
            dst             <= 32'd0;
            data            <= 32'd0;
            count           <= 10'd0;
            sramAddress     <= 14'd0;
            sramWriteData   <= 32'd0;
            sramWriteEnable <= 1'b0;
            dramAddress     <= 32'd0;
            dramWriteData   <= 32'd0;
            dramWriteEnable <= 1'b0;
            dramReadEnable  <= 1'b0;
            stall           <= 1'b0;
`ifdef SIMT_DMAC_TIMEOUT_EN
            to_count        <= 32'd0;
            dmaError        <= 1'b0;
`endif
        end else begin
            sramAddress     <= 14'd0;
            sramWriteData   <= 32'd0;
            sramWriteEnable <= 1'b0;
            dramAddress     <= 32'd0;
            dramWriteData   <= 32'd0;
            dramWriteEnable <= 1'b0;
            dramReadEnable  <= 1'b0;
`ifdef SIMT_DMAC_TIMEOUT_EN
            to_count        <= 32'd0;
`endif
            unique case (state)
                IDLE: begin
                    if (cmd_d2s || cmd_s2d) begin
                        src   <= dmaSrcAddress;
                        dst   <= dmaDstAddress;
                        count <= dmaWidth;
                        stall <= 1'b1;
                        if (cmd_d2s) begin
                            state          <= D2S_RD;
                            dramReadEnable <= 1'b1;
                            dramAddress    <= dmaSrcAddress;
                        end else begin
                            state       <= S2D_RD;
                            sramAddress <= dmaSrcAddress[15:2];
                        end
                    end
                end
                D2S_RD: begin
                    if (dramValid) begin
                        data            <= dramReadData;
                        state           <= D2S_WR;
                        sramWriteEnable <= 1'b1;
                        sramAddress     <= dst[15:2];
                        sramWriteData   <= dramReadData;
                    end else if (timed_out) begin
                        state <= IDLE;
                        stall <= 1'b0;
`ifdef SIMT_DMAC_TIMEOUT_EN
                        dmaError <= 1'b1;
`endif
                    end else begin
                        dramReadEnable <= 1'b1;
                        dramAddress    <= src;
`ifdef SIMT_DMAC_TIMEOUT_EN
                        to_count       <= to_count + 32'd1;
`endif
                    end
                end
                D2S_WR: begin
                    src   <= src_next;
                    dst   <= dst_next;
                    count <= count - 10'd1;
                    if (last_word) begin
                        state <= IDLE;
                        stall <= 1'b0;
                    end else begin
                        state          <= D2S_RD;
                        dramReadEnable <= 1'b1;
                        dramAddress    <= src_next;
                    end
                end
                S2D_RD: begin
                    data            <= sramReadData;
                    state           <= S2D_WR;
                    dramWriteEnable <= 1'b1;
                    dramAddress     <= dst;
                    dramWriteData   <= sramReadData;
                end
                S2D_WR: begin
                    if (dramValid) begin
                        src   <= src_next;
                        dst   <= dst_next;
                        count <= count - 10'd1;
                        if (last_word) begin
                            state <= IDLE;
                            stall <= 1'b0;
                        end else begin
                            state       <= S2D_RD;
                            sramAddress <= src_next[15:2];
                        end
                    end else if (timed_out) begin
                        state <= IDLE;
                        stall <= 1'b0;
`ifdef SIMT_DMAC_TIMEOUT_EN
                        dmaError <= 1'b1;
`endif
                    end else begin
                        // Request held stable until the DRAM acknowledges it.
                        dramWriteEnable <= 1'b1;
                        dramAddress     <= dst;
                        dramWriteData   <= data;
`ifdef SIMT_DMAC_TIMEOUT_EN
                        to_count        <= to_count + 32'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

endmodule
